// File: rtl/seq_min_sort.sv
// seq_min_sort: loads a batch of M words of N bits in one handshake and then
// streams the participating words out one per cycle in ascending (or
// descending) order. Each output element carries the word's original index.
// Each selection is an MSB-to-LSB bit-slice elimination over the words that
// have not yet been emitted. Ties go to the lowest index, so equal words keep
// their input order.
//
// Valid/ready semantics (both the batch input and the element output):
// a transfer happens on a rising clock edge where valid and ready are both 1.
// The producer holds valid and its payload stable until that edge. The
// consumer may change ready freely. Valid never depends combinationally on
// ready.
//
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_valid/o_ready batch handshake; i_data (word k = i_data[k]), i_mask, i_desc
//   o_valid/i_ready element handshake; o_data, o_idx, o_last
//   o_busy          a batch is being emitted (state SORT)
//   o_state         debug view of the FSM state (0 = IDLE, 1 = SORT)
module seq_min_sort #(
  parameter int M = 8,
  parameter int N = 16,
  localparam int IW = $clog2(M)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [M-1:0][N-1:0] i_data,
  input  logic [M-1:0]        i_mask,
  input  logic                i_desc,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [N-1:0]        o_data,
  output logic [IW-1:0]       o_idx,
  output logic                o_last,
  output logic                o_busy,
  output logic                o_state
);

  typedef enum logic {
    IDLE = 1'b0,
    SORT = 1'b1
  } state_t;

  state_t               state_q;
  logic [M-1:0][N-1:0]  data_q;
  logic                 desc_q;
  logic [M-1:0]         act_q;

  logic [M-1:0]         hit;
  logic [M-1:0]         col;
  logic [IW-1:0]        sel;
  logic                 last;

  // Bit-slice elimination. In descending mode each word is compared in
  // inverted form, so the minimum of ~w is the maximum of w. A slice that is
  // uniform over the surviving set cannot separate them and is skipped.
  always_comb begin
    hit = act_q;
    col = '0;
    for (int j = N - 1; j >= 0; j--) begin
      for (int k = 0; k < M; k++) begin
        col[k] = data_q[k][j] ^ desc_q;
      end
      if ((|(hit & col)) && (|(hit & ~col))) begin
        hit = hit & ~col;
      end
    end
    // Lowest surviving index wins, which keeps equal words in input order.
    sel = '0;
    for (int k = M - 1; k >= 0; k--) begin
      if (hit[k]) begin
        sel = IW'(k);
      end
    end
  end

  // Exactly one active word remains.
  assign last = (act_q != '0) && ((act_q & (act_q - M'(1))) == '0);

  assign o_state = state_q;
  assign o_ready = (state_q == IDLE);
  assign o_busy  = (state_q == SORT);
  assign o_valid = (state_q == SORT);
  assign o_data  = o_valid ? data_q[sel] : '0;
  assign o_idx   = o_valid ? sel : '0;
  assign o_last  = o_valid & last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      desc_q  <= 1'b0;
      act_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            data_q <= i_data;
            desc_q <= i_desc;
            act_q  <= i_mask;
            // An empty mask is accepted but produces no output.
            if (i_mask != '0) begin
              state_q <= SORT;
            end
          end
        end
        SORT: begin
          if (i_ready) begin
            act_q[sel] <= 1'b0;
            if (last) begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_min_sort.sv
module tb_seq_min_sort;
  localparam int M  = 4;
  localparam int N  = 8;
  localparam int IW = $clog2(M);
  localparam int W  = N + IW + 1;

  logic                i_clk;
  logic                i_rst_n;
  logic                i_valid;
  logic                o_ready;
  logic [M-1:0][N-1:0] i_data;
  logic [M-1:0]        i_mask;
  logic                i_desc;
  logic                o_valid;
  logic                i_ready;
  logic [N-1:0]        o_data;
  logic [IW-1:0]       o_idx;
  logic                o_last;
  logic                o_busy;
  logic                o_state;

  int n_cmp = 0;
  int n_err = 0;

  // Expected elements as {data, idx, last}.
  logic [W-1:0] exp_q[$];

  seq_min_sort #(.M(M), .N(N)) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_data (i_data),
    .i_mask (i_mask),
    .i_desc (i_desc),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_data (o_data),
    .o_idx  (o_idx),
    .o_last (o_last),
    .o_busy (o_busy),
    .o_state(o_state)
  );

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // ---------------- drivers ----------------
  function automatic logic [M-1:0][N-1:0] pack(input logic [N-1:0] d0, d1, d2, d3);
    pack = {d3, d2, d1, d0};
  endfunction

  // Presents one batch for one cycle and pushes the expected sorted stream.
  // The reference model is a plain repeated min/max search with strict
  // comparison, so the lowest index wins on ties.
  task automatic load(input logic [M-1:0][N-1:0] d, input logic [M-1:0] m, input logic desc);
    logic [M-1:0] act;
    int best;
    n_cmp++;
    if (o_ready !== 1'b1) begin
      $display("FAIL load_ready: o_ready=%b want 1", o_ready);
      n_err++;
    end
    i_data  = d;
    i_mask  = m;
    i_desc  = desc;
    i_valid = 1'b1;
    act = m;
    while (act != '0) begin
      best = -1;
      for (int k = 0; k < M; k++) begin
        if (act[k]) begin
          if (best < 0) best = k;
          else if (desc ? (d[k] > d[best]) : (d[k] < d[best])) best = k;
        end
      end
      act[best] = 1'b0;
      exp_q.push_back({d[best], IW'(best), (act == '0)});
    end
    tick();
    i_valid = 1'b0;
  endtask

  // Consumes elements from the DUT and compares them against the scoreboard.
  // stall_after: handshakes before a stall of stall_len cycles (-1 = none).
  // rnd: random i_ready. stop_after: stop after this many handshakes (-1 = all).
  task automatic drain(input int stall_after, input int stall_len, input bit rnd,
                       input int stop_after);
    int done = 0;
    int stalled = 0;
    int cycles = 0;
    logic [W-1:0] exp;
    while (exp_q.size() > 0 && (stop_after < 0 || done < stop_after)) begin
      if (cycles > 200) begin
        n_cmp++;
        n_err++;
        $display("FAIL drain_timeout: %0d elements still expected", exp_q.size());
        exp_q.delete();
        break;
      end
      cycles++;
      if (stall_after >= 0 && done == stall_after && stalled < stall_len) begin
        i_ready = 1'b0;
        stalled++;
      end else if (rnd) begin
        i_ready = ($urandom_range(0, 3) != 0);
      end else begin
        i_ready = 1'b1;
      end
      n_cmp++;
      if (o_valid !== 1'b1 || o_busy !== 1'b1) begin
        $display("FAIL stream_valid: o_valid=%b o_busy=%b want 1 1", o_valid, o_busy);
        n_err++;
      end else begin
        exp = exp_q[0];
        if ({o_data, o_idx, o_last} !== exp) begin
          $display("FAIL element: got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b (ready=%b)",
                   o_data, o_idx, o_last, exp[W-1 -: N], exp[IW:1], exp[0], i_ready);
          n_err++;
        end
        if (i_ready) begin
          void'(exp_q.pop_front());
          done++;
        end
      end
      tick();
    end
    i_ready = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_data  = '0;
    i_mask  = '0;
    i_desc  = 1'b0;
    #12;
    n_cmp++;
    if ({o_ready, o_valid, o_busy, o_data, o_idx, o_last} !== {1'b1, 1'b0, 1'b0, {N{1'b0}}, {IW{1'b0}}, 1'b0}) begin
      $display("FAIL reset_outputs: ready=%b valid=%b busy=%b data=%h idx=%0d last=%b want 1 0 0 00 0 0",
               o_ready, o_valid, o_busy, o_data, o_idx, o_last);
      n_err++;
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ascending();
    load(pack(8'h30, 8'h10, 8'h20, 8'h10), 4'b1111, 1'b0);
    drain(-1, 0, 1'b0, -1);
    n_cmp++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      $display("FAIL asc_after: ready=%b valid=%b want 1 0", o_ready, o_valid);
      n_err++;
    end
  endtask

  task automatic test_descending();
    load(pack(8'h30, 8'h10, 8'h20, 8'h10), 4'b1111, 1'b1);
    drain(-1, 0, 1'b0, -1);
    n_cmp++;
    if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
      $display("FAIL desc_after: ready=%b busy=%b want 1 0", o_ready, o_busy);
      n_err++;
    end
  endtask

  task automatic test_mask();
    load(pack(8'h30, 8'h10, 8'h20, 8'h10), 4'b1010, 1'b0);
    drain(-1, 0, 1'b0, -1);
    n_cmp++;
    if (o_valid !== 1'b0) begin
      $display("FAIL mask_after: o_valid=%b want 0", o_valid);
      n_err++;
    end
  endtask

  task automatic test_ties_stall();
    load(pack(8'hFF, 8'hFF, 8'hFF, 8'hFF), 4'b1111, 1'b0);
    drain(1, 3, 1'b0, -1);
    n_cmp++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      $display("FAIL ties_after: valid=%b ready=%b want 0 1", o_valid, o_ready);
      n_err++;
    end
  endtask

  task automatic test_empty_mask();
    load(pack(8'h01, 8'h02, 8'h03, 8'h04), 4'b0000, 1'b0);
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
        $display("FAIL empty_mask: valid=%b ready=%b busy=%b want 0 1 0", o_valid, o_ready, o_busy);
        n_err++;
      end
      tick();
    end
  endtask

  task automatic test_ignore_valid();
    load(pack(8'h05, 8'h03, 8'h07, 8'h01), 4'b1111, 1'b0);
    // A competing batch offered while the block is busy must be ignored.
    i_valid = 1'b1;
    i_data  = pack(8'h00, 8'h00, 8'h00, 8'h00);
    i_mask  = 4'b1111;
    i_desc  = 1'b1;
    n_cmp++;
    if (o_ready !== 1'b0) begin
      $display("FAIL busy_ready: o_ready=%b want 0", o_ready);
      n_err++;
    end
    drain(-1, 0, 1'b0, 2);
    i_valid = 1'b0;
    drain(-1, 0, 1'b0, -1);
    n_cmp++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      $display("FAIL ignore_after: valid=%b ready=%b want 0 1", o_valid, o_ready);
      n_err++;
    end
  endtask

  task automatic test_reset_mid_batch();
    load(pack(8'h40, 8'h30, 8'h20, 8'h10), 4'b1111, 1'b0);
    drain(-1, 0, 1'b0, 2);
    i_rst_n = 1'b0;
    #1;
    n_cmp++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_ready !== 1'b1) begin
      $display("FAIL reset_mid: valid=%b busy=%b ready=%b want 0 0 1", o_valid, o_busy, o_ready);
      n_err++;
    end
    exp_q.delete();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    tick();
    n_cmp++;
    if (o_valid !== 1'b0) begin
      $display("FAIL reset_release: o_valid=%b want 0", o_valid);
      n_err++;
    end
    load(pack(8'h09, 8'h0C, 8'h02, 8'h0C), 4'b1111, 1'b1);
    drain(-1, 0, 1'b0, -1);
  endtask

  task automatic test_random();
    logic [M-1:0][N-1:0] d;
    for (int b = 0; b < 6; b++) begin
      for (int k = 0; k < M; k++) d[k] = N'($urandom_range(0, 5) * 37);
      load(d, M'($urandom_range(1, 15)), 1'($urandom_range(0, 1)));
      drain(-1, 0, 1'b1, -1);
      n_cmp++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
        $display("FAIL random_after: batch %0d valid=%b ready=%b want 0 1", b, o_valid, o_ready);
        n_err++;
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_ascending();
    test_descending();
    test_mask();
    test_ties_stall();
    test_empty_mask();
    test_ignore_valid();
    test_reset_mid_batch();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
